// File: rtl/uart_cmd_ctrl.sv
// UART command-frame controller: hunts SYNC, checks an XOR-protected frame and replays its payload as register writes.
// Optional inter-byte timeout is built in when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_ctrl #(
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         MAX_LEN = 16,
    parameter int         LEN_BIT = 5,
    parameter int         TO_CYC  = 1_000_000,
    parameter int         TO_BIT  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    output logic       reg_wr,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       busy
);

    localparam int                 BUF_AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]         MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [LEN_BIT-1:0] IDX_ONE   = LEN_BIT'(1);

    if ((2 ** LEN_BIT) <= MAX_LEN || (2 ** TO_BIT) <= TO_CYC || MAX_LEN < 1 || MAX_LEN > 255)
    begin : g_param_check
        $error("uart_cmd_ctrl: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CHK,
        S_WRITE
    } state_t;

    state_t             state, state_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         chk_q, chk_d;
    logic [LEN_BIT-1:0] len_q, len_d;
    logic [LEN_BIT-1:0] idx_q, idx_d;
    logic               reg_wr_d, frame_ok_d, frame_err_d;
    logic [7:0]         reg_addr_d, reg_wdata_d;
    logic               buf_we;
    logic               consuming;
    logic               pop;
    logic [7:0]         pay_buf [MAX_LEN];

`ifdef UART_CMD_TIMEOUT_EN
    localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TO_CYC - 1);
    localparam logic [TO_BIT-1:0] TO_ONE  = TO_BIT'(1);
    logic [TO_BIT-1:0] to_cnt_q, to_cnt_d;
`endif

    assign consuming = (state != S_WRITE);
    assign pop       = consuming & ~rx_empty;
    assign rd_uart   = pop & ~reset;
    assign busy      = (state != S_IDLE);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state;
        addr_d      = addr_q;
        chk_d       = chk_q;
        len_d       = len_q;
        idx_d       = idx_q;
        reg_wr_d    = 1'b0;
        reg_addr_d  = reg_addr;
        reg_wdata_d = reg_wdata;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        buf_we      = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (pop && r_data == SYNC) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (pop) begin
                    addr_d  = r_data;
                    chk_d   = r_data;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (pop) begin
                    if (r_data == 8'h00 || r_data > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        len_d   = LEN_BIT'(r_data);
                        chk_d   = chk_q ^ r_data;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (pop) begin
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ r_data;
                    idx_d  = idx_q + IDX_ONE;
                    if (idx_q + IDX_ONE == len_q) state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (pop) begin
                    if (r_data == chk_q) begin
                        // Outputs are registered, so the first write is launched here;
                        // idx then counts writes already presented.
                        reg_wr_d    = 1'b1;
                        reg_addr_d  = addr_q;
                        reg_wdata_d = pay_buf[0];
                        frame_ok_d  = (len_q == IDX_ONE);
                        idx_d       = IDX_ONE;
                        state_d     = S_WRITE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                if (idx_q == len_q) begin
                    state_d = S_IDLE;
                end else begin
                    reg_wr_d    = 1'b1;
                    reg_addr_d  = addr_q + 8'(idx_q);
                    reg_wdata_d = pay_buf[idx_q[BUF_AW-1:0]];
                    frame_ok_d  = (idx_q + IDX_ONE == len_q);
                    idx_d       = idx_q + IDX_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef UART_CMD_TIMEOUT_EN
        to_cnt_d = '0;
        if (state != S_IDLE && state != S_WRITE && rx_empty) begin
            if (to_cnt_q == TO_LAST) begin
                frame_err_d = 1'b1;
                state_d     = S_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TO_ONE;
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            chk_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            addr_q    <= addr_d;
            chk_q     <= chk_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            reg_wr    <= reg_wr_d;
            reg_addr  <= reg_addr_d;
            reg_wdata <= reg_wdata_d;
            frame_ok  <= frame_ok_d;
            frame_err <= frame_err_d;
        end
    end

`ifdef UART_CMD_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end
`endif

    // NOTE: the payload store has no reset; every entry is written before a write burst reads it.
    always_ff @(posedge clk) begin
        if (buf_we) pay_buf[idx_q[BUF_AW-1:0]] <= r_data;
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: a byte-queue FIFO model feeds directed frames, a monitor checks
// every reg_wr / frame_ok / frame_err against hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       rx_empty  = 1'b1;
    logic [7:0] r_data    = 8'h00;
    logic       rd_uart;
    logic       reg_wr;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       frame_ok;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.TO_CYC(100)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .busy      (busy)
    );

    typedef struct packed {
        logic       is_err;
        logic [7:0] addr;
        logic [7:0] data;
        logic       ok;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       mon_e;
    logic [7:0] fifo  [$];
    logic [7:0] frm   [$];
    int         n_vec = 0;
    int         n_miss = 0;
    logic       burst_pending = 1'b0;
    logic       fifo_pop;
    int         lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void refresh();
        rx_empty = (fifo.size() == 0);
        r_data   = rx_empty ? 8'h00 : fifo[0];
    endfunction

    task automatic exp_wr(input logic [7:0] a, input logic [7:0] d, input logic ok);
        exp_t e;
        e.is_err = 1'b0; e.addr = a; e.data = d; e.ok = ok;
        exp_q.push_back(e);
    endtask

    task automatic exp_err();
        exp_t e;
        e.is_err = 1'b1; e.addr = 8'h00; e.data = 8'h00; e.ok = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic send_frm();
        foreach (frm[i]) fifo.push_back(frm[i]);
        refresh();
    endtask

    // Counts negedges until the chosen pulse appears; the cycle of the push is cycle 0.
    task automatic measure(input logic want_err, input int budget, output int cyc);
        logic seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            seen = want_err ? frame_err : frame_ok;
        end
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while ((fifo.size() != 0 || busy || exp_q.size() != 0) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        check({tag, "_scoreboard_empty"}, exp_q.size(), 0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    // FIFO model: pop decision sampled at the edge, queue updated just after it.
    always @(posedge clk) begin
        fifo_pop = rd_uart;
        #1;
        if (fifo_pop && fifo.size() > 0) fifo.delete(0);
        refresh();
    end

    // Monitor: pops one expectation per observed event.
    always @(negedge clk) begin
        if (reset) begin
            burst_pending = 1'b0;
        end else begin
            if (frame_ok && frame_err) begin
                n_vec++;
                n_miss++;
                $display("FAIL ok_err_same_cycle: got ok=1 err=1, required at most one (t=%0t)", $time);
            end
            if (burst_pending) begin
                check("wr_burst_consecutive", reg_wr, 1'b1);
                burst_pending = 1'b0;
            end
            if (reg_wr || frame_ok || frame_err) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_event: got wr=%0b addr=%0h data=%0h ok=%0b err=%0b, required no event (t=%0t)",
                             reg_wr, reg_addr, reg_wdata, frame_ok, frame_err, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("evt_frame_err", frame_err, mon_e.is_err);
                    check("evt_reg_wr", reg_wr, !mon_e.is_err);
                    if (!mon_e.is_err) begin
                        check("wr_addr", reg_addr, mon_e.addr);
                        check("wr_data", reg_wdata, mon_e.data);
                        check("wr_frame_ok", frame_ok, mon_e.ok);
                        burst_pending = !mon_e.ok;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a byte waiting: rd_uart must stay low.
        fifo.push_back(8'h00);
        refresh();
        repeat (3) @(negedge clk);
        check("rst_rd_uart", rd_uart, 1'b0);
        check("rst_reg_wr", reg_wr, 1'b0);
        check("rst_frame_ok", frame_ok, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_reg_addr", reg_addr, 8'h00);
        check("rst_reg_wdata", reg_wdata, 8'h00);
        reset = 1'b0;
        wait_done("boot");

        // Good frame: 10^03^11^22^33 = 13.
        frm = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13};
        exp_wr(8'h10, 8'h11, 1'b0);
        exp_wr(8'h11, 8'h22, 1'b0);
        exp_wr(8'h12, 8'h33, 1'b1);
        send_frm();
        measure(1'b0, 60, lat);
        // SYNC, ADDR, LEN, 3 data, CHK in cycles 0..6; writes in cycles 7..9.
        check("good_ok_latency", lat, 9);
        wait_done("good");

        // Bad checksum followed immediately by a good frame.
        frm = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h14,
                8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13};
        exp_err();
        exp_wr(8'h10, 8'h11, 1'b0);
        exp_wr(8'h11, 8'h22, 1'b0);
        exp_wr(8'h12, 8'h33, 1'b1);
        send_frm();
        measure(1'b1, 60, lat);
        check("badchk_err_latency", lat, 7);
        wait_done("badchk");

        // Zero length: error in the cycle after the LEN pop.
        frm = '{8'hA5, 8'h20, 8'h00};
        exp_err();
        send_frm();
        measure(1'b1, 60, lat);
        check("len0_err_latency", lat, 3);
        wait_done("len0");

        // Length 17 exceeds MAX_LEN.
        frm = '{8'hA5, 8'h20, 8'h11};
        exp_err();
        send_frm();
        measure(1'b1, 60, lat);
        check("len17_err_latency", lat, 3);
        wait_done("len17");

        // Sync hunt: 40^01^77 = 36.
        frm = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h40, 8'h01, 8'h77, 8'h36};
        exp_wr(8'h40, 8'h77, 1'b1);
        send_frm();
        wait_done("hunt");

        // Address wrap with SYNC value inside payload: FE^03^A5^01^02 = 5B.
        frm = '{8'hA5, 8'hFE, 8'h03, 8'hA5, 8'h01, 8'h02, 8'h5B};
        exp_wr(8'hFE, 8'hA5, 1'b0);
        exp_wr(8'hFF, 8'h01, 1'b0);
        exp_wr(8'h00, 8'h02, 1'b1);
        send_frm();
        wait_done("wrap");

        // Reset during WRITE: only the first of three writes may appear. 30^03^01^02^03 = 33.
        frm = '{8'hA5, 8'h30, 8'h03, 8'h01, 8'h02, 8'h03, 8'h33};
        exp_wr(8'h30, 8'h01, 1'b0);
        send_frm();
        lat = 0;
        while (!reg_wr && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("rstwr_first_write_seen", reg_wr, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rstwr_reg_wr_drop", reg_wr, 1'b0);
        check("rstwr_frame_ok_low", frame_ok, 1'b0);
        check("rstwr_busy_low", busy, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_done("rstwr");

`ifdef UART_CMD_TIMEOUT_EN
        // Timeout: ADDR popped in cycle 1, 100 empty cycles follow, error seen in cycle 102.
        frm = '{8'hA5, 8'h10};
        exp_err();
        send_frm();
        measure(1'b1, 300, lat);
        check("timeout_err_latency", lat, 102);
        wait_done("timeout");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
